// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port RAM between the icache and dcache. One word-sized
// transaction is in flight at a time. Dcache has priority. A saturating
// starve counter lets icache through after STARVE_LIMIT consecutive
// dcache completions while icache was waiting.
//
// Ports
//   CLK, nRST               clock, async active-low reset
//   iREN, iaddr             icache read request / word address
//   iwait, iload            icache handshake (low = done this cycle) / read data
//   dREN, dWEN, daddr, dstore   dcache request, address, write data
//   dwait, dload            dcache handshake / read data
//   ramREN, ramWEN, ramaddr, ramstore   RAM command (registered)
//   ramload, ramstate       RAM read data / status (00 FREE 01 BUSY 10 ACCESS 11 ERROR)
//   igrant_cnt, dgrant_cnt  completed transaction counters (wrap)
//
// state  | meaning
// IDLE   | no grant, RAM command lines all zero
// IGRANT | icache owns the RAM until ACCESS or iREN drops
// DGRANT | dcache owns the RAM until ACCESS or dREN|dWEN drops
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [31:0] igrant_cnt,
    output logic [31:0] dgrant_cnt
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   igrant_cnt_q, igrant_cnt_d;
    logic [31:0]   dgrant_cnt_q, dgrant_cnt_d;
    logic          ram_ren_q, ram_ren_d;
    logic          ram_wen_q, ram_wen_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_store_q, ram_store_d;

    logic dreq;
    logic ram_done;

    assign dreq     = dREN | dWEN;
    // ERROR is deliberately not a completion; only ACCESS ends a grant.
    assign ram_done = (ramstate == RAM_ACCESS);

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        igrant_cnt_d = igrant_cnt_q;
        dgrant_cnt_d = dgrant_cnt_q;
        ram_ren_d    = 1'b0;
        ram_wen_d    = 1'b0;
        ram_addr_d   = '0;
        ram_store_d  = '0;

        case (state_q)
            IDLE: begin
                if (dreq && (!iREN || starve_q < STARVE_MAX)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                if (ram_done) begin
                    state_d      = IDLE;
                    igrant_cnt_d = igrant_cnt_q + 32'd1;
                    starve_d     = '0;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (ram_done) begin
                    state_d      = IDLE;
                    dgrant_cnt_d = dgrant_cnt_q + 32'd1;
                    if (!iREN) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (!dreq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // RAM command is registered from the next state so enables appear
        // right after the granting edge and drop right after a release.
        case (state_d)
            IGRANT: begin
                ram_ren_d  = 1'b1;
                ram_addr_d = iaddr;
            end
            DGRANT: begin
                ram_addr_d  = daddr;
                ram_store_d = dstore;
                // A simultaneous read+write request is served as the write.
                ram_wen_d   = dWEN;
                ram_ren_d   = !dWEN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            igrant_cnt_q <= '0;
            dgrant_cnt_q <= '0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_store_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            igrant_cnt_q <= igrant_cnt_d;
            dgrant_cnt_q <= dgrant_cnt_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            ram_addr_q   <= ram_addr_d;
            ram_store_q  <= ram_store_d;
        end
    end

    assign iwait      = !((state_q == IGRANT) && ram_done);
    assign dwait      = !((state_q == DGRANT) && ram_done);
    assign iload      = ramload;
    assign dload      = ramload;
    assign ramREN     = ram_ren_q;
    assign ramWEN     = ram_wen_q;
    assign ramaddr    = ram_addr_q;
    assign ramstore   = ram_store_q;
    assign igrant_cnt = igrant_cnt_q;
    assign dgrant_cnt = dgrant_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] FREE_S   = 2'b00;
    localparam logic [1:0] BUSY_S   = 2'b01;
    localparam logic [1:0] ACCESS_S = 2'b10;
    localparam logic [1:0] ERROR_S  = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore, igrant_cnt, dgrant_cnt;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // inputs are driven 2 time units after the rising edge, outputs sampled 1 later
    task automatic next_cycle();
        @(posedge CLK);
        #2;
    endtask

    typedef struct {
        logic        iren, dren, dwen;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iwait, e_dwait;
        logic [31:0] e_icnt, e_dcnt;
    } vec_t;

    vec_t tbl[8];

    // reference model state for the random phase
    int          owner;          // 0 none, 1 icache, 2 dcache
    int          m_starve;
    logic [31:0] m_icnt, m_dcnt, g_addr, g_store;
    logic        g_wen;
    bit          i_done, d_done, drop;
    int          rem;
    int          k;
    int          n_done;
    string       seq [10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0,        FREE_S,   1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'd0, 32'd1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h1111,     BUSY_S,   1'b1, 1'b0, 32'h40, 32'h0,    1'b1, 1'b1, 32'd0, 32'd1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h2222,     BUSY_S,   1'b1, 1'b0, 32'h40, 32'h0,    1'b1, 1'b1, 32'd0, 32'd1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, ACCESS_S, 1'b1, 1'b0, 32'h40, 32'h0,    1'b0, 1'b1, 32'd0, 32'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0, 32'h0,        FREE_S,   1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'd1, 32'd1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h80, 32'h1234, 32'h0,    FREE_S,   1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'd1, 32'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h80, 32'h1234, 32'h5555, ACCESS_S, 1'b0, 1'b1, 32'h80, 32'h1234, 1'b1, 1'b0, 32'd1, 32'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0, 32'h0,        FREE_S,   1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'd1, 32'd2};

        // reset with both requests held
        nRST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h20; daddr = 32'h10; dstore = 32'h0;
        ramload = 32'h0; ramstate = FREE_S;
        repeat (3) @(posedge CLK);
        #3;
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_icnt", igrant_cnt, 0);
        chk("rst_dcnt", dgrant_cnt, 0);
        @(negedge CLK) nRST = 1'b1;
        next_cycle(); #1;
        chk("first_grant_ramREN", ramREN, 1);
        chk("first_grant_addr", ramaddr, 32'h10);
        next_cycle(); ramstate = ACCESS_S; ramload = 32'hA5A5A5A5; #1;
        chk("first_grant_dwait", dwait, 0);
        chk("first_grant_iwait", iwait, 1);
        chk("first_grant_dload", dload, 32'hA5A5A5A5);
        next_cycle(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE_S; #1;
        chk("first_grant_dcnt", dgrant_cnt, 1);

        // table: icache read with 2 BUSY cycles, then dcache read+write
        for (int r = 0; r < 8; r++) begin
            next_cycle();
            iREN = tbl[r].iren; dREN = tbl[r].dren; dWEN = tbl[r].dwen;
            iaddr = tbl[r].ia; daddr = tbl[r].da; dstore = tbl[r].ds;
            ramload = tbl[r].rl; ramstate = tbl[r].rs;
            #1;
            chk($sformatf("tbl%0d_ramREN", r), ramREN, tbl[r].e_ren);
            chk($sformatf("tbl%0d_ramWEN", r), ramWEN, tbl[r].e_wen);
            chk($sformatf("tbl%0d_ramaddr", r), ramaddr, tbl[r].e_addr);
            chk($sformatf("tbl%0d_ramstore", r), ramstore, tbl[r].e_store);
            chk($sformatf("tbl%0d_iwait", r), iwait, tbl[r].e_iwait);
            chk($sformatf("tbl%0d_dwait", r), dwait, tbl[r].e_dwait);
            chk($sformatf("tbl%0d_iload", r), iload, tbl[r].rl);
            chk($sformatf("tbl%0d_dload", r), dload, tbl[r].rl);
            chk($sformatf("tbl%0d_icnt", r), igrant_cnt, tbl[r].e_icnt);
            chk($sformatf("tbl%0d_dcnt", r), dgrant_cnt, tbl[r].e_dcnt);
        end

        // starvation guard: both held, zero-wait RAM
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; iaddr = 32'h500; daddr = 32'h600;
        n_done = 0;
        for (int c = 0; c < 40 && n_done < 10; c++) begin
            next_cycle();
            ramstate = (ramREN || ramWEN) ? ACCESS_S : FREE_S;
            #1;
            if (!dwait) begin seq[n_done] = "D"; n_done++; end
            else if (!iwait) begin seq[n_done] = "I"; n_done++; end
        end
        chk("starve_completions", n_done, 10);
        for (int j = 0; j < 10; j++) begin
            n_total++;
            if (seq[j] == ((j % 5 == 4) ? "I" : "D")) n_pass++;
            else $display("FAIL starve_seq%0d: got '%s' expected '%s'", j, seq[j], (j % 5 == 4) ? "I" : "D");
        end
        next_cycle(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE_S; #1;
        chk("starve_icnt", igrant_cnt, 3);
        chk("starve_dcnt", dgrant_cnt, 10);

        // ERROR is not completion
        next_cycle(); dREN = 1'b1; daddr = 32'h100; ramstate = FREE_S; #1;
        for (int j = 0; j < 5; j++) begin
            next_cycle(); ramstate = ERROR_S; #1;
            chk("err_dwait", dwait, 1);
            chk("err_ramREN", ramREN, 1);
            chk("err_dcnt", dgrant_cnt, 10);
        end
        next_cycle(); ramstate = ACCESS_S; #1;
        chk("err_access_dwait", dwait, 0);
        next_cycle(); dREN = 1'b0; ramstate = FREE_S; #1;
        chk("err_dcnt_after", dgrant_cnt, 11);

        // icache drops its request mid-grant, pending dcache follows
        next_cycle(); iREN = 1'b1; iaddr = 32'h200; #1;
        next_cycle(); ramstate = BUSY_S; dREN = 1'b1; daddr = 32'h300; #1;
        chk("drop_ramaddr", ramaddr, 32'h200);
        next_cycle(); iREN = 1'b0; #1;
        chk("drop_still_granted", ramREN, 1);
        chk("drop_iwait", iwait, 1);
        next_cycle(); #1;
        chk("drop_idle_ramREN", ramREN, 0);
        chk("drop_icnt", igrant_cnt, 3);
        next_cycle(); #1;
        chk("drop_dgrant_ramaddr", ramaddr, 32'h300);
        next_cycle(); ramstate = ACCESS_S; #1;
        chk("drop_dgrant_dwait", dwait, 0);
        next_cycle(); dREN = 1'b0; ramstate = FREE_S; #1;
        chk("drop_dcnt", dgrant_cnt, 12);

        // asynchronous reset in the middle of a grant
        next_cycle(); dREN = 1'b1; daddr = 32'h400; #1;
        next_cycle(); ramstate = BUSY_S; #1;
        chk("mid_rst_pre_ramREN", ramREN, 1);
        nRST = 1'b0; #1;
        chk("mid_rst_ramREN", ramREN, 0);
        chk("mid_rst_ramaddr", ramaddr, 0);
        chk("mid_rst_dwait", dwait, 1);
        chk("mid_rst_dcnt", dgrant_cnt, 0);
        chk("mid_rst_icnt", igrant_cnt, 0);
        dREN = 1'b0; ramstate = FREE_S;
        @(negedge CLK) nRST = 1'b1;
        next_cycle(); #1;
        chk("mid_rst_after_dcnt", dgrant_cnt, 0);

        // randomized traffic against the reference model
        owner = 0; m_starve = 0; m_icnt = 0; m_dcnt = 0;
        g_addr = 0; g_store = 0; g_wen = 0;
        i_done = 0; d_done = 0; rem = 0;
        iREN = 0; dREN = 0; dWEN = 0;
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            drop = 0;
            if (!iREN) begin
                if ($urandom_range(0, 2) == 0) begin iREN = 1'b1; iaddr = $urandom; end
            end else if (i_done) begin
                if ($urandom_range(0, 1) == 0) iREN = 1'b0;
                else iaddr = $urandom;
            end else if ($urandom_range(0, 39) == 0) begin
                iREN = 1'b0; drop = 1;
            end
            if (!(dREN || dWEN)) begin
                if ($urandom_range(0, 2) == 0) begin
                    k = $urandom_range(0, 2);
                    dREN = (k != 1); dWEN = (k != 0);
                    daddr = $urandom; dstore = $urandom;
                end
            end else if (d_done) begin
                if ($urandom_range(0, 1) == 0) begin dREN = 1'b0; dWEN = 1'b0; end
                else begin daddr = $urandom; dstore = $urandom; end
            end else if ($urandom_range(0, 39) == 0) begin
                dREN = 1'b0; dWEN = 1'b0; drop = 1;
            end
            if (!(ramREN || ramWEN)) begin
                rem = $urandom_range(0, 3);
                ramstate = 2'($urandom_range(0, 3));
            end else if (rem > 0 || drop) begin
                k = $urandom_range(0, 2);
                ramstate = (k == 0) ? BUSY_S : (k == 1) ? ERROR_S : FREE_S;
                if (rem > 0) rem--;
            end else begin
                ramstate = ACCESS_S;
            end
            ramload = $urandom;
            #1;
            chk("rnd_ramREN", ramREN, (owner == 1) || (owner == 2 && !g_wen));
            chk("rnd_ramWEN", ramWEN, (owner == 2) && g_wen);
            chk("rnd_ramaddr", ramaddr, (owner != 0) ? g_addr : 32'h0);
            chk("rnd_ramstore", ramstore, (owner == 2) ? g_store : 32'h0);
            chk("rnd_iwait", iwait, !(owner == 1 && ramstate == ACCESS_S));
            chk("rnd_dwait", dwait, !(owner == 2 && ramstate == ACCESS_S));
            chk("rnd_iload", iload, ramload);
            chk("rnd_dload", dload, ramload);
            chk("rnd_icnt", igrant_cnt, m_icnt);
            chk("rnd_dcnt", dgrant_cnt, m_dcnt);

            i_done = (owner == 1 && ramstate == ACCESS_S);
            d_done = (owner == 2 && ramstate == ACCESS_S);
            if (owner == 0) begin
                if ((dREN || dWEN) && (!iREN || m_starve < LIMIT)) begin
                    owner = 2; g_addr = daddr; g_store = dstore; g_wen = dWEN;
                end else if (iREN) begin
                    owner = 1; g_addr = iaddr; g_store = 0; g_wen = 0;
                end
            end else if (owner == 1) begin
                if (i_done) begin m_icnt++; m_starve = 0; owner = 0; end
                else if (!iREN) owner = 0;
            end else begin
                if (d_done) begin
                    m_dcnt++;
                    m_starve = iREN ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
                    owner = 0;
                end else if (!(dREN || dWEN)) owner = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
